ycbcr_block_buffer: RTL and testbench
=====================================

# ycbcr_block_buffer

Double-buffered 8x8 block assembler directly downstream of the RGB-to-YCbCr converter. Captures 64 packed {Y, Cb, Cr} pixels per block, already in 8x8 block raster order, into one of two banks. Drains a completed bank as three component-planar 64-sample bursts (Y, then Cb, then Cr) toward the DCT stage over a valid/ready interface. The converter has no backpressure, so the input side is push-only with an overflow flag.

## Interface
- DATA_W, 10, signed width of each component sample; packed input is 3*DATA_W.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  pixel present on in_pix. Upstream derives it by delaying its issue strobe 2 cycles to match converter latency.
- in_pix  in  3*DATA_W  {y[29:20], cb[19:10], cr[9:0]}, each signed.
- bank_free  out  1  at least one bank EMPTY or FILLING; upstream starts a new block only when high.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  DATA_W  signed sample.
- out_comp  out  2  0=Y, 1=Cb, 2=Cr; 3 never driven.
- out_idx  out  6  raster index within block, 0..63.
- out_last  out  1  high with comp=2, idx=63.
- overflow  out  1  sticky; set when in_valid arrives while the write bank is not EMPTY/FILLING. Cleared only by rst.

## Operation
- Bank states: EMPTY, FILLING, FULL, DRAINING. Reset: both EMPTY, wr_bank=0, rd_bank=0, wr_idx=0, rd_cnt=0.
- Write: an accepted in_valid stores in_pix at [wr_bank][wr_idx].
  - First write moves the bank EMPTY->FILLING.
  - wr_idx==63 moves the bank to FULL, wraps wr_idx to 0 and toggles wr_bank.
- A write to a FULL/DRAINING bank is dropped, sets overflow, and does not advance wr_idx.
- Drain FSM:
  - IDLE: if bank rd_bank is FULL, mark it DRAINING, rd_cnt=0, go DRAIN.
  - DRAIN: rd_cnt 0..191 selects comp = rd_cnt/64 and idx = rd_cnt%64. out_data is the matching slice of the stored word.
  - The output register advances only on out_valid && out_ready, or when the register is empty.
  - On handshake with out_last: bank goes EMPTY, rd_bank toggles, FSM returns to IDLE. It re-enters DRAIN on the next cycle if the other bank is already FULL.
- Data is passed unmodified; no level shift or clipping.
- Mid-block reset: all state returns to reset values. Partial contents are discarded, not flushed.

## Timing
- Reset values: out_valid=0, out_data=0, out_comp=0, out_idx=0, out_last=0, overflow=0, bank_free=1.
- Outputs are registered and held stable while out_valid && !out_ready.
- Latency: the 64th write sampled at edge t makes the bank FULL at t; the first Y sample has out_valid=1 after edge t+2 (IDLE->DRAIN at t+1, output register at t+2).
- Throughput: 1 sample/cycle with out_ready held high, so 192 cycles per block versus 64 fill cycles. Upstream must gate on bank_free.
- Release and refill in the same cycle: an EMPTY transition is visible from the next edge. A same-cycle write to that bank counts as overflow.
- bank_free is combinational from the registered bank states.

## Structure
- Package jpeg_pkg: COMP_Y=0, COMP_CB=1, COMP_CR=2, BLK_PIXELS=64, bank-state enum.
- Sub-module ycbcr_bank_ram: 2x64x(3*DATA_W) storage with one synchronous write port and one read port. Read latency is absorbed by the IDLE->DRAIN cycle.
- Top level holds the write counter, bank-state registers, drain FSM and output register.

## Test plan
- Single block, pixel k = {Y=k, Cb=-k, Cr=k+100}, out_ready=1 -> 192 outputs:
  - Y0..63 = 0..63, then Cb = 0..-63, then Cr = 100..163.
  - out_last only on the last output; first out_valid 2 cycles after the 64th write.
- Random out_ready (50%) over 4 back-to-back blocks -> output stream identical to the ready=1 case; out_data stable while stalled.
- Three blocks pushed with no gap while out_ready=0 -> first two fill both banks, bank_free drops after block 2, third block's first pixel sets overflow and is dropped, and banks 0/1 are intact on drain.
- Bank release and write in the same cycle -> write dropped, overflow=1.
- rst asserted at wr_idx=30 and again mid-drain at rd_cnt=100 -> all outputs return to reset values immediately; the next full block drains correctly from idx 0.
- Boundary values Y=+511, Cb=-511 (0x201), Cr=0 -> bit-exact passthrough, sign preserved.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared constants and state types for the YCbCr block buffer.
// Component codes, block geometry and the bank/drain state encodings.
package jpeg_pkg;

    localparam logic [1:0] COMP_Y  = 2'd0;
    localparam logic [1:0] COMP_CB = 2'd1;
    localparam logic [1:0] COMP_CR = 2'd2;

    localparam int BLK_PIXELS = 64;
    localparam int NUM_COMPS  = 3;
    localparam int DRAIN_LEN  = NUM_COMPS * BLK_PIXELS;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL,
        BANK_DRAINING
    } bank_state_t;

    typedef enum logic {
        DR_IDLE,
        DR_DRAIN
    } drain_state_t;

    // A bank may accept pixels only while it is not holding a finished block.
    function automatic logic bank_writable(input bank_state_t s);
        return (s == BANK_EMPTY) || (s == BANK_FILLING);
    endfunction

endpackage

// File: rtl/ycbcr_bank_ram.sv
// Two banks of 64 packed {Y, Cb, Cr} words; one synchronous write port and
// one registered read port, addressed as {bank, idx}.
module ycbcr_bank_ram
    import jpeg_pkg::*;
#(
    parameter int WORD_W = 30
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [5:0]        wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [5:0]        rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    localparam int DEPTH = 2 * BLK_PIXELS;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_data_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= wr_data;
        end
    end

    // Read register holds its value while the drain side is stalled.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_reg <= mem[{rd_bank, rd_idx}];
        end
    end

    assign rd_data = rd_data_reg;

endmodule

// File: rtl/ycbcr_block_buffer.sv
// Double-buffered 8x8 block assembler: push-only pixel capture into two banks,
// drained as planar Y, Cb, Cr bursts over a valid/ready output register.
module ycbcr_block_buffer
    import jpeg_pkg::*;
#(
    parameter int DATA_W = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [3*DATA_W-1:0] in_pix,
    output logic                bank_free,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_comp,
    output logic [5:0]          out_idx,
    output logic                out_last,
    output logic                overflow
);

    localparam int PIX_W = 3 * DATA_W;

    // Bank bookkeeping and write side
    bank_state_t bank_state_reg [2];
    logic        wr_bank_reg;
    logic [5:0]  wr_idx_reg;
    logic        overflow_reg;
    logic        wr_accept;
    logic        wr_drop;
    logic        wr_last;

    // Drain side
    drain_state_t drain_reg;
    drain_state_t drain_next;
    logic         rd_bank_reg;
    logic [7:0]   rd_cnt_reg;
    logic [7:0]   rd_cnt_next;
    logic [7:0]   rd_cnt_inc;
    logic         claim;
    logic         bank_release;
    logic         load;
    logic         rd_en;
    logic [5:0]   rd_idx;
    logic [PIX_W-1:0] rd_word;
    logic [DATA_W-1:0] comp_word [NUM_COMPS];
    logic [DATA_W-1:0] sel_sample;

    // Output register
    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic [1:0]        out_comp_reg;
    logic [5:0]        out_idx_reg;
    logic              out_last_reg;
    logic              handshake;

    assign wr_accept = in_valid && bank_writable(bank_state_reg[wr_bank_reg]);
    assign wr_drop   = in_valid && !bank_writable(bank_state_reg[wr_bank_reg]);
    assign wr_last   = (wr_idx_reg == 6'(BLK_PIXELS - 1));
    assign bank_free = bank_writable(bank_state_reg[0]) || bank_writable(bank_state_reg[1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_reg  <= 1'b0;
            wr_idx_reg   <= 6'd0;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_idx_reg <= wr_idx_reg + 6'd1;
                if (wr_last) begin
                    wr_bank_reg <= ~wr_bank_reg;
                end
            end
            if (wr_drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Writer and drainer act on disjoint states of a bank, so at most one
    // branch can fire for a given bank in any cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bank_state_reg[b] <= BANK_EMPTY;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (wr_accept && (wr_bank_reg == 1'(b))) begin
                    bank_state_reg[b] <= wr_last ? BANK_FULL : BANK_FILLING;
                end else if (claim && (rd_bank_reg == 1'(b))) begin
                    bank_state_reg[b] <= BANK_DRAINING;
                end else if (bank_release && (rd_bank_reg == 1'(b))) begin
                    bank_state_reg[b] <= BANK_EMPTY;
                end
            end
        end
    end

    ycbcr_bank_ram #(
        .WORD_W (PIX_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_bank (wr_bank_reg),
        .wr_idx  (wr_idx_reg),
        .wr_data (in_pix),
        .rd_en   (rd_en),
        .rd_bank (rd_bank_reg),
        .rd_idx  (rd_idx),
        .rd_data (rd_word)
    );

    // Unpack the stored word into Y, Cb, Cr (MSB first).
    for (genvar gi = 0; gi < NUM_COMPS; gi++) begin : g_comp
        assign comp_word[gi] = rd_word[PIX_W - 1 - gi*DATA_W -: DATA_W];
    end

    always_comb begin
        case (rd_cnt_reg[7:6])
            COMP_Y:  sel_sample = comp_word[0];
            COMP_CB: sel_sample = comp_word[1];
            default: sel_sample = comp_word[2];
        endcase
    end

    assign handshake  = out_valid_reg && out_ready;
    assign rd_cnt_inc = rd_cnt_reg + 8'd1;

    // rd_word always holds the pixel for the current rd_cnt: the first read is
    // issued on the claim cycle, each later one alongside the output load.
    always_comb begin
        drain_next   = drain_reg;
        rd_cnt_next  = rd_cnt_reg;
        rd_en        = 1'b0;
        rd_idx       = rd_cnt_inc[5:0];
        claim        = 1'b0;
        bank_release = 1'b0;
        load         = 1'b0;
        case (drain_reg)
            DR_IDLE: begin
                if (bank_state_reg[rd_bank_reg] == BANK_FULL) begin
                    claim       = 1'b1;
                    rd_en       = 1'b1;
                    rd_idx      = 6'd0;
                    rd_cnt_next = 8'd0;
                    drain_next  = DR_DRAIN;
                end
            end
            DR_DRAIN: begin
                if (handshake && out_last_reg) begin
                    bank_release = 1'b1;
                    drain_next   = DR_IDLE;
                end else if ((rd_cnt_reg != 8'(DRAIN_LEN)) && (!out_valid_reg || out_ready)) begin
                    load        = 1'b1;
                    rd_en       = 1'b1;
                    rd_cnt_next = rd_cnt_inc;
                end
            end
            default: begin
                drain_next = DR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_reg   <= DR_IDLE;
            rd_cnt_reg  <= 8'd0;
            rd_bank_reg <= 1'b0;
        end else begin
            drain_reg  <= drain_next;
            rd_cnt_reg <= rd_cnt_next;
            if (bank_release) begin
                rd_bank_reg <= ~rd_bank_reg;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_comp_reg  <= 2'd0;
            out_idx_reg   <= 6'd0;
            out_last_reg  <= 1'b0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sel_sample;
            out_comp_reg  <= rd_cnt_reg[7:6];
            out_idx_reg   <= rd_cnt_reg[5:0];
            out_last_reg  <= (rd_cnt_reg == 8'(DRAIN_LEN - 1));
        end else if (handshake) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_comp  = out_comp_reg;
    assign out_idx   = out_idx_reg;
    assign out_last  = out_last_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// Self-checking bench for ycbcr_block_buffer: blocks are modelled as arrays of
// component values and expanded into the expected planar output stream.
module tb_ycbcr_block_buffer;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [3*DW-1:0] in_pix;
    logic          bank_free;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    out_comp;
    logic [5:0]    out_idx;
    logic          out_last;
    logic          overflow;

    always #5 clk = ~clk;

    ycbcr_block_buffer #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pix    (in_pix),
        .bank_free (bank_free),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_comp  (out_comp),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    typedef struct packed {
        logic [1:0]    comp;
        logic [5:0]    idx;
        logic [DW-1:0] data;
        logic          last;
    } smp_t;

    smp_t rx_q[$];
    smp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   stall_err = 0;
    int   blk_y[64];
    int   blk_cb[64];
    int   blk_cr[64];
    smp_t prev_s;
    bit   prev_stall = 1'b0;

    // Output collector and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (out_valid !== 1'b1 ||
                smp_t'({out_comp, out_idx, out_data, out_last}) !== prev_s))
                stall_err++;
            if (out_valid && out_ready)
                rx_q.push_back(smp_t'({out_comp, out_idx, out_data, out_last}));
            prev_stall = out_valid && !out_ready;
            prev_s = smp_t'({out_comp, out_idx, out_data, out_last});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [3*DW-1:0] p);
        in_valid = 1'b1;
        in_pix   = p;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [3*DW-1:0] pack_pix(input int k);
        return {10'(blk_y[k]), 10'(blk_cb[k]), 10'(blk_cr[k])};
    endfunction

    task automatic send_block();
        for (int k = 0; k < 64; k++) send_pixel(pack_pix(k));
    endtask

    // Expected planar stream: all Y in raster order, then all Cb, then all Cr.
    task automatic model_block();
        smp_t s;
        int v;
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < 64; i++) begin
                v = (c == 0) ? blk_y[i] : (c == 1) ? blk_cb[i] : blk_cr[i];
                s.comp = 2'(c);
                s.idx  = 6'(i);
                s.data = 10'(v);
                s.last = (c == 2) && (i == 63);
                exp_q.push_back(s);
            end
        end
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 64; k++) begin
            blk_y[k] = k; blk_cb[k] = -k; blk_cr[k] = k + 100;
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < 64; k++) begin
            blk_y[k]  = int'($urandom_range(0, 1023)) - 512;
            blk_cb[k] = int'($urandom_range(0, 1023)) - 512;
            blk_cr[k] = int'($urandom_range(0, 1023)) - 512;
        end
    endtask

    task automatic wait_rx(input int target, input int limit);
        for (int i = 0; i < limit && rx_q.size() < target; i++) tick();
    endtask

    function automatic int count_mismatch(input int base, input int n, output int first);
        int m = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            if (base + i >= rx_q.size() || rx_q[base + i] !== exp_q[i]) begin
                if (m == 0) first = i;
                m++;
            end
        end
        return m;
    endfunction

    function automatic smp_t got_at(input int i);
        smp_t s = 'x;
        if (i >= 0 && i < rx_q.size()) s = rx_q[i];
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_pix = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_pix = '0; out_ready = 1'b0;
        tick(); tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 10'd0) begin bad++; $display("FAIL rst_data: got %h want 000", out_data); end
        total++; if (out_comp !== 2'd0) begin bad++; $display("FAIL rst_comp: got %0d want 0", out_comp); end
        total++; if (out_idx !== 6'd0) begin bad++; $display("FAIL rst_idx: got %0d want 0", out_idx); end
        total++; if (out_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b want 0", out_last); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow: got %b want 0", overflow); end
        total++; if (bank_free !== 1'b1) begin bad++; $display("FAIL rst_bank_free: got %b want 1", bank_free); end
        rst = 1'b0;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_single_block();
        int base, mm, first, n;
        do_reset();
        out_ready = 1'b1;
        base = rx_q.size();
        fill_ramp();
        model_block();
        send_block();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_t0: out_valid got %b want 0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_t1: out_valid got %b want 0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 10'd0 || out_comp !== 2'd0 || out_idx !== 6'd0)
            begin bad++; $display("FAIL lat_t2: got v=%b d=%h c=%0d i=%0d want v=1 d=000 c=0 i=0", out_valid, out_data, out_comp, out_idx); end
        wait_rx(base + 192, 400);
        repeat (10) tick();
        n = rx_q.size() - base;
        total++; if (n !== 192) begin bad++; $display("FAIL single_count: got %0d want 192", n); end
        mm = count_mismatch(base, 192, first);
        total++; if (mm !== 0) begin bad++; $display("FAIL single_stream: %0d wrong, first %0d got %h want %h", mm, first, got_at(base + first), exp_q[first]); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL single_overflow: got %b want 0", overflow); end
        $display("test_single_block: %0d samples received", n);
    endtask

    task automatic test_boundary();
        int base, mm, first;
        smp_t s0, s64;
        do_reset();
        out_ready = 1'b1;
        base = rx_q.size();
        for (int k = 0; k < 64; k++) begin
            blk_y[k]  = (k % 2 == 0) ? 511 : -512;
            blk_cb[k] = (k % 2 == 0) ? -511 : 511;
            blk_cr[k] = (k % 2 == 0) ? 0 : -1;
        end
        model_block();
        send_block();
        wait_rx(base + 192, 400);
        repeat (5) tick();
        mm = count_mismatch(base, 192, first);
        total++; if (mm !== 0) begin bad++; $display("FAIL bound_stream: %0d wrong, first %0d got %h want %h", mm, first, got_at(base + first), exp_q[first]); end
        s0 = got_at(base);
        s64 = got_at(base + 64);
        total++; if (s0.data !== 10'h1FF) begin bad++; $display("FAIL bound_y: got %h want 1ff", s0.data); end
        total++; if (s64.data !== 10'h201) begin bad++; $display("FAIL bound_cb: got %h want 201", s64.data); end
        $display("test_boundary: done");
    endtask

    task automatic test_back_to_back();
        int base, mm, first, stall0, n, cyc;
        do_reset();
        base = rx_q.size();
        stall0 = stall_err;
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    cyc = 0;
                    while (!bank_free && cyc < 3000) begin tick(); cyc++; end
                    fill_random();
                    model_block();
                    send_block();
                end
            end
            begin
                int w = 0;
                while (rx_q.size() < base + 768 && w < 8000) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                    w++;
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) tick();
        n = rx_q.size() - base;
        total++; if (n !== 768) begin bad++; $display("FAIL b2b_count: got %0d want 768", n); end
        mm = count_mismatch(base, 768, first);
        total++; if (mm !== 0) begin bad++; $display("FAIL b2b_stream: %0d wrong, first %0d got %h want %h", mm, first, got_at(base + first), exp_q[first]); end
        total++; if (stall_err - stall0 !== 0) begin bad++; $display("FAIL b2b_stall: %0d unstable stalled cycles, want 0", stall_err - stall0); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
        $display("test_back_to_back: %0d samples received", n);
    endtask

    task automatic test_overflow();
        int base, mm, first, n, stall0;
        do_reset();
        out_ready = 1'b0;
        base = rx_q.size();
        stall0 = stall_err;
        fill_random(); model_block(); send_block();
        fill_random(); model_block(); send_block();
        total++; if (bank_free !== 1'b0) begin bad++; $display("FAIL ovf_bank_free: got %b want 0", bank_free); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b want 0", overflow); end
        fill_random();
        send_pixel(pack_pix(0));
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        for (int k = 1; k < 4; k++) send_pixel(pack_pix(k));
        repeat (5) tick();
        out_ready = 1'b1;
        wait_rx(base + 384, 1000);
        repeat (10) tick();
        n = rx_q.size() - base;
        total++; if (n !== 384) begin bad++; $display("FAIL ovf_count: got %0d want 384", n); end
        mm = count_mismatch(base, 384, first);
        total++; if (mm !== 0) begin bad++; $display("FAIL ovf_stream: %0d wrong, first %0d got %h want %h", mm, first, got_at(base + first), exp_q[first]); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        total++; if (stall_err - stall0 !== 0) begin bad++; $display("FAIL ovf_stall: %0d unstable stalled cycles, want 0", stall_err - stall0); end
        $display("test_overflow: %0d samples received", n);
    endtask

    task automatic test_release_refill();
        int base, mm, first, n;
        bit seen;
        do_reset();
        out_ready = 1'b1;
        base = rx_q.size();
        fill_random(); model_block(); send_block();
        fill_random(); model_block(); send_block();
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (out_valid && out_last) seen = 1'b1;
            else tick();
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL rr_last_seen: got %b want 1", seen); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rr_before: got %b want 0", overflow); end
        send_pixel(30'h2AAAAAAA);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL rr_overflow: got %b want 1", overflow); end
        total++; if (bank_free !== 1'b1) begin bad++; $display("FAIL rr_bank_free: got %b want 1", bank_free); end
        fill_random(); model_block(); send_block();
        wait_rx(base + 576, 1500);
        repeat (10) tick();
        n = rx_q.size() - base;
        total++; if (n !== 576) begin bad++; $display("FAIL rr_count: got %0d want 576", n); end
        mm = count_mismatch(base, 576, first);
        total++; if (mm !== 0) begin bad++; $display("FAIL rr_stream: %0d wrong, first %0d got %h want %h", mm, first, got_at(base + first), exp_q[first]); end
        $display("test_release_refill: %0d samples received", n);
    endtask

    task automatic test_mid_reset();
        int base, mm, first, n;
        do_reset();
        out_ready = 1'b1;
        fill_random();
        for (int k = 0; k < 30; k++) send_pixel(pack_pix(k));
        rst = 1'b1;
        #1;
        total++; if (bank_free !== 1'b1 || overflow !== 1'b0 || out_valid !== 1'b0)
            begin bad++; $display("FAIL mr_fill_rst: got free=%b ovf=%b v=%b want 1 0 0", bank_free, overflow, out_valid); end
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
        base = rx_q.size();
        fill_random(); model_block(); send_block();
        wait_rx(base + 100, 400);
        mm = count_mismatch(base, 100, first);
        total++; if (mm !== 0) begin bad++; $display("FAIL mr_partial_stream: %0d wrong, first %0d got %h want %h", mm, first, got_at(base + first), exp_q[first]); end
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 10'd0 || out_comp !== 2'd0 || out_idx !== 6'd0 || out_last !== 1'b0)
            begin bad++; $display("FAIL mr_drain_rst: got v=%b d=%h c=%0d i=%0d l=%b want all 0", out_valid, out_data, out_comp, out_idx, out_last); end
        total++; if (bank_free !== 1'b1) begin bad++; $display("FAIL mr_bank_free: got %b want 1", bank_free); end
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
        base = rx_q.size();
        fill_random(); model_block(); send_block();
        wait_rx(base + 192, 400);
        repeat (10) tick();
        n = rx_q.size() - base;
        total++; if (n !== 192) begin bad++; $display("FAIL mr_count: got %0d want 192", n); end
        mm = count_mismatch(base, 192, first);
        total++; if (mm !== 0) begin bad++; $display("FAIL mr_stream: %0d wrong, first %0d got %h want %h", mm, first, got_at(base + first), exp_q[first]); end
        $display("test_mid_reset: %0d samples received", n);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_pix = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_block();
        test_boundary();
        test_back_to_back();
        test_overflow();
        test_release_refill();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
